// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// fft_pkg : shared widths, constants and capture-state type for fft_frame_tx
// Rev 1.0
// ============================================================================
package fft_pkg;
  localparam int         ADC_W        = 12;
  localparam int         FFT_OUT_W    = 23;
  localparam int         PTS_W        = 11;
  localparam logic [1:0] FFT_ERR_NONE = 2'b00;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_CAP  = 1'b1
  } cap_state_e;

  // Offset-binary to two's complement is just an MSB flip.
  function automatic logic [ADC_W-1:0] adc_conv(input logic [ADC_W-1:0] raw, input logic offset);
    return offset ? {~raw[ADC_W-1], raw[ADC_W-2:0]} : raw;
  endfunction
endpackage
`default_nettype wire

// File: rtl/fft_tx_fifo.sv
`default_nettype none
// ============================================================================
// fft_tx_fifo : synchronous sample FIFO, head read straight from storage
// Rev 1.0
// ============================================================================
module fft_tx_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule
`default_nettype wire

// File: rtl/fft_frame_tx.sv
`default_nettype none
// ============================================================================
// fft_frame_tx : frames the ADC stream into whole FFT_PTS Avalon-ST packets
// Rev 1.0
// ============================================================================
module fft_frame_tx
  import fft_pkg::*;
#(
  parameter int FFT_PTS    = 1024,
  parameter int FIFO_DEPTH = 16,
  parameter int ADC_OFFSET = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] adc_data,
  output logic             fft_sink_valid,
  input  logic             fft_sink_ready,
  output logic [1:0]       fft_sink_error,
  output logic             fft_sink_sop,
  output logic             fft_sink_eop,
  output logic [ADC_W-1:0] fft_sink_real,
  output logic [ADC_W-1:0] fft_sink_imag,
  output logic [PTS_W-1:0] fft_fftpts_in,
  output logic             fft_inverse,
  output logic             busy,
  output logic [15:0]      overflow_cnt,
  output logic [15:0]      frame_cnt
);
  localparam logic [PTS_W-1:0] LAST_IDX = PTS_W'(FFT_PTS - 1);

  cap_state_e       state_q, state_d;
  logic [PTS_W-1:0] wcnt_q, wcnt_d;
  logic [PTS_W-1:0] rcnt_q, rcnt_d;
  logic [15:0]      overflow_q, overflow_d;
  logic [15:0]      frame_q, frame_d;
  logic             fifo_full, fifo_empty;
  logic [ADC_W-1:0] fifo_head;
  logic             wr_req, wr_ok, rd_ok;

  fft_tx_fifo #(
    .WIDTH (ADC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (wr_req),
    .pop     (rd_ok),
    .wdata   (adc_conv(adc_data, ADC_OFFSET != 0)),
    .rdata   (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    rd_ok      = !fifo_empty && fft_sink_ready;
    wr_req     = (state_q == W_CAP) && adc_valid;
    wr_ok      = wr_req && (!fifo_full || rd_ok);
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    rcnt_d     = rcnt_q;
    overflow_d = overflow_q;
    frame_d    = frame_q;

    // enable only matters at a frame boundary; a running frame always completes.
    case (state_q)
      W_IDLE: begin
        if (enable) begin
          state_d = W_CAP;
          wcnt_d  = '0;
        end
      end
      W_CAP: begin
        if (wr_ok) begin
          if (wcnt_q == LAST_IDX) begin
            wcnt_d = '0;
            if (!enable) state_d = W_IDLE;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      default: state_d = W_IDLE;
    endcase

    if (wr_req && !wr_ok && overflow_q != 16'hFFFF) overflow_d = overflow_q + 16'd1;

    if (rd_ok) begin
      if (rcnt_q == LAST_IDX) begin
        rcnt_d  = '0;
        frame_d = frame_q + 16'd1;
      end else begin
        rcnt_d = rcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= W_IDLE;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      overflow_q <= '0;
      frame_q    <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      overflow_q <= overflow_d;
      frame_q    <= frame_d;
    end
  end

  assign fft_sink_valid = !fifo_empty;
  assign fft_sink_sop   = !fifo_empty && (rcnt_q == '0);
  assign fft_sink_eop   = !fifo_empty && (rcnt_q == LAST_IDX);
  assign fft_sink_real  = fifo_empty ? '0 : fifo_head;
  assign fft_sink_imag  = '0;
  assign fft_sink_error = FFT_ERR_NONE;
  assign fft_fftpts_in  = PTS_W'(FFT_PTS);
  assign fft_inverse    = 1'b0;
  assign busy           = (state_q == W_CAP) || !fifo_empty;
  assign overflow_cnt   = overflow_q;
  assign frame_cnt      = frame_q;
endmodule
`default_nettype wire
